// File: rtl/spm_pipe_wrap.sv
`default_nettype none
// ============================================================================
// Module  : spm_pipe_wrap (with embedded serial-parallel multiplier core spm)
// Brief   : Parallel handshake wrapper that serialises b into the spm core and
//           deserialises the signed 2*SIZE-bit product.
// Revision: 1.0
// ============================================================================

module spm #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [SIZE-1:0] x,
    input  logic            y,
    output logic            p
);
    localparam int W = 2 * SIZE;

    logic [W-1:0] w_xe;
    logic [W-1:0] w_pp;
    logic [W-1:0] w_sin;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_carry;
    logic [W-1:0] r_s;
    logic [W-1:0] r_c;

    // Carry-save chain: sums shift toward cell 0, carries stay in place.
    // x is sign-extended across the full width so the low 2*SIZE bits are exact.
    assign w_xe    = {{SIZE{x[SIZE-1]}}, x};
    assign w_pp    = w_xe & {W{y}};
    assign w_sin   = {1'b0, r_s[W-1:1]};
    assign w_sum   = w_sin ^ w_pp ^ r_c;
    assign w_carry = (w_sin & w_pp) | (w_sin & r_c) | (w_pp & r_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s <= '0;
            r_c <= '0;
        end else if (clr) begin
            r_s <= '0;
            r_c <= '0;
        end else begin
            r_s <= w_sum;
            r_c <= w_carry;
        end
    end

    assign p = r_s[0];

endmodule

module spm_pipe_wrap #(
    parameter int SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] product,
    output logic              busy
);
    localparam int W  = 2 * SIZE;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] C_LAST = CW'(W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [SIZE-1:0] r_a;
    logic [W-1:0]    r_b_sh;
    logic [W-1:0]    r_prod_sh;
    logic [CW-1:0]   r_cnt;
    logic            r_y;
    logic            r_clr;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;
    logic            w_core_p;

    spm #(
        .SIZE(SIZE)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .clr (r_clr),
        .x   (r_a),
        .y   (r_y),
        .p   (w_core_p)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b_sh      <= '0;
            r_prod_sh   <= '0;
            r_cnt       <= '0;
            r_y         <= 1'b0;
            r_clr       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b_sh     <= {{SIZE{b[SIZE-1]}}, b};
                        r_clr      <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_cnt   <= '0;
                    r_y     <= r_b_sh[0];
                    r_b_sh  <= r_b_sh >> 1;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // The core output lags y by one cycle, so capture starts at cnt=1.
                    if (r_cnt != '0) begin
                        r_prod_sh <= {w_core_p, r_prod_sh[W-1:1]};
                    end
                    if (r_cnt == C_LAST) begin
                        r_y         <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_y    <= (r_cnt < C_LAST - CW'(1)) ? r_b_sh[0] : 1'b0;
                        r_b_sh <= r_b_sh >> 1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = r_prod_sh;

endmodule

`default_nettype wire

// File: tb/tb_spm_pipe_wrap.sv
`default_nettype none
// ============================================================================
// Module  : tb_spm_pipe_wrap
// Brief   : Scoreboard bench for spm_pipe_wrap (SIZE=32).
// Revision: 1.0
// ============================================================================

module tb_spm_pipe_wrap;
    localparam int SIZE = 32;
    localparam int W    = 2 * SIZE;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SIZE-1:0] a = '0;
    logic [SIZE-1:0] b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    product;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] sb_q[$];

    spm_pipe_wrap #(
        .SIZE(SIZE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return W'(p);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [SIZE-1:0] xa, input logic [SIZE-1:0] xb, output bit tmo);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        tmo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                sb_q.push_back(model(xa, xb));
                step();
                tmo = 1'b0;
                break;
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles, output bit tmo);
        cycles = 0;
        tmo = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (out_valid) begin
                tmo = 1'b0;
                break;
            end
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b busy=%b prod=%h required 1 0 0 0",
                     in_ready, out_valid, busy, product);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bit t1, t2;
        int cyc;
        logic [W-1:0] exp;
        out_ready = 1'b1;
        issue(32'd3, 32'd5, t1);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: got busy=%b rdy=%b required 1 0", busy, in_ready);
        end
        wait_out(cyc, t2);
        n_checks++;
        if (t1 || t2) begin
            n_fail++;
            $display("FAIL basic_timeout: got tmo_in=%b tmo_out=%b required 0 0", t1, t2);
        end
        n_checks++;
        if (cyc !== 66) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d cycles required 66", cyc);
        end
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        n_checks++;
        if (product !== 64'd15 || product !== exp) begin
            n_fail++;
            $display("FAIL basic_product: got %h required %h", product, 64'd15);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: got vld=%b rdy=%b busy=%b required 0 1 0",
                     out_valid, in_ready, busy);
        end
    endtask

    task automatic test_signed();
        logic [SIZE-1:0] ta[4];
        logic [SIZE-1:0] tb_[4];
        logic [W-1:0]    tr[4];
        bit t1, t2;
        int cyc;
        logic [W-1:0] exp;
        ta[0] = -32'sd7;        tb_[0] = 32'sd6;          tr[0] = 64'hFFFF_FFFF_FFFF_FFD6;
        ta[1] = 32'sd6;         tb_[1] = -32'sd7;         tr[1] = 64'hFFFF_FFFF_FFFF_FFD6;
        ta[2] = 32'h8000_0000;  tb_[2] = 32'h8000_0000;   tr[2] = 64'h4000_0000_0000_0000;
        ta[3] = 32'h7FFF_FFFF;  tb_[3] = 32'hFFFF_FFFF;   tr[3] = 64'hFFFF_FFFF_8000_0001;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb_[i], t1);
            wait_out(cyc, t2);
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
            n_checks++;
            if (t1 || t2 || product !== tr[i]) begin
                n_fail++;
                $display("FAIL signed_%0d: got %h required %h (tmo=%b%b)", i, product, tr[i], t1, t2);
            end
            n_checks++;
            if (product !== exp) begin
                n_fail++;
                $display("FAIL signed_model_%0d: got %h required %h", i, product, exp);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        bit t1, t2;
        int cyc;
        logic [W-1:0] exp;
        out_ready = 1'b0;
        issue(32'd1234, -32'sd99, t1);
        wait_out(cyc, t2);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        n_checks++;
        if (t1 || t2) begin
            n_fail++;
            $display("FAIL bp_timeout: got tmo_in=%b tmo_out=%b required 0 0", t1, t2);
        end
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            a = $urandom;
            b = $urandom;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got vld=%b rdy=%b prod=%h required 1 0 %h",
                         i, out_valid, in_ready, product, exp);
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit t1, t2;
        int cyc;
        logic [W-1:0] exp;
        out_ready = 1'b1;
        issue(32'd123, 32'd456, t1);
        for (int i = 0; i < 18; i++) step();
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%b vld=%b busy=%b prod=%h required 1 0 0 0",
                     in_ready, out_valid, busy, product);
        end
        sb_q.delete();
        step();
        rst = 1'b0;
        step();
        issue(32'd2, 32'd3, t1);
        wait_out(cyc, t2);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        n_checks++;
        if (t1 || t2 || product !== 64'd6 || exp !== 64'd6) begin
            n_fail++;
            $display("FAIL after_reset_op: got %h required %h (tmo=%b%b)", product, 64'd6, t1, t2);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int done   = 0;
        logic [W-1:0] exp;
        a = $urandom;
        b = $urandom;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 20000 && done < 50; cyc++) begin
            bit fin, fout;
            out_ready = 1'($urandom_range(0, 1));
            fin  = in_valid && in_ready;
            fout = out_valid && out_ready;
            if (fin) sb_q.push_back(model(a, b));
            if (fout) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected: got %h required no output", product);
                end else begin
                    exp = sb_q.pop_front();
                    if (product !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_product_%0d: got %h required %h", done, product, exp);
                    end
                end
                done++;
            end
            step();
            if (fin) begin
                issued++;
                if (issued < 50) begin
                    a = $urandom;
                    b = $urandom;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (done != 50) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d products required 50", done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
